// File: rtl/pkg_teclado.sv
// Shared keypad definitions: special key codes and the entry FSM state type.
package pkg_teclado;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } entrada_t;

endpackage

// File: rtl/module_operando.sv
// One BCD operand: a digit shift register plus a digit count.
//   clk, rst_in  : clock, async active-low reset
//   push, digit  : shift a new digit in at the least-significant position
//   pop          : drop the least-significant digit
//   clr          : zero value and count (wins over push/pop)
//   val, cnt     : current operand and its number of digits
//   full, empty  : count == N_DIGITS / count == 0
module module_operando #(
  parameter int N_DIGITS = 3,
  parameter int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr,
  input  logic [3:0]            digit,
  output logic [4*N_DIGITS-1:0] val,
  output logic [CW-1:0]         cnt,
  output logic                  full,
  output logic                  empty
);

  localparam int W = 4 * N_DIGITS;

  logic [W-1:0]  val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(N_DIGITS));
  assign empty = (cnt_q == '0);
  assign val   = val_q;
  assign cnt   = cnt_q;

  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr) begin
      val_d = '0;
      cnt_d = '0;
    end else if (push && !full) begin
      val_d = (val_q << 4) | W'(digit);
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      val_d = val_q >> 4;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/module_control_entrada.sv
// Keypad entry controller: builds operands A and B from key strobes and
// hands the pair downstream with a valid/ready handshake.
//   clk, rst_in        : clock, async active-low reset
//   key_code, key_pulse: key value, qualified by a one-cycle strobe
//   op_a, op_b         : BCD operands, LS digit in [3:0]
//   disp, cnt          : operand being edited and its digit count
//   sel_b              : operand B selected (ENTER_B or DONE)
//   ops_valid/ops_ready: operand pair handshake
//   key_err            : one-cycle pulse for a rejected key
module module_control_entrada
  import pkg_teclado::*;
#(
  parameter int N_DIGITS = 3,
  parameter int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic [3:0]            key_code,
  input  logic                  key_pulse,
  output logic [4*N_DIGITS-1:0] op_a,
  output logic [4*N_DIGITS-1:0] op_b,
  output logic [4*N_DIGITS-1:0] disp,
  output logic [CW-1:0]         cnt,
  output logic                  sel_b,
  output logic                  ops_valid,
  input  logic                  ops_ready,
  output logic                  key_err
);

  entrada_t state_q, state_d;
  logic     key_err_q, key_err_d;

  logic a_push, a_pop, a_clr, a_full, a_empty;
  logic b_push, b_pop, b_clr, b_full, b_empty;
  logic [CW-1:0] a_cnt, b_cnt;

  logic is_digit, is_enter, is_back, is_bad, flush;

  assign is_digit = (key_code <= 4'd9);
  assign is_enter = (key_code == KEY_ENTER);
  assign is_back  = (key_code == KEY_BACK);
  assign is_bad   = (key_code >= 4'hD);
  // CLEAR and a completed handshake both return to a blank ENTER_A.
  assign flush    = (key_pulse && key_code == KEY_CLR) ||
                    (state_q == DONE && ops_ready);

  module_operando #(.N_DIGITS(N_DIGITS), .CW(CW)) u_op_a (
    .clk(clk), .rst_in(rst_in), .push(a_push), .pop(a_pop), .clr(a_clr),
    .digit(key_code), .val(op_a), .cnt(a_cnt), .full(a_full), .empty(a_empty)
  );

  module_operando #(.N_DIGITS(N_DIGITS), .CW(CW)) u_op_b (
    .clk(clk), .rst_in(rst_in), .push(b_push), .pop(b_pop), .clr(b_clr),
    .digit(key_code), .val(op_b), .cnt(b_cnt), .full(b_full), .empty(b_empty)
  );

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ENTER_A;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_err_q <= key_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ENTER_A;
    end else if (key_pulse) begin
      case (state_q)
        ENTER_A: if (is_enter && !a_empty) state_d = ENTER_B;
        ENTER_B: begin
          if (is_enter && !b_empty)     state_d = DONE;
          else if (is_back && b_empty)  state_d = ENTER_A;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    a_push    = 1'b0;
    a_pop     = 1'b0;
    a_clr     = 1'b0;
    b_push    = 1'b0;
    b_pop     = 1'b0;
    b_clr     = 1'b0;
    key_err_d = 1'b0;
    if (flush) begin
      a_clr = 1'b1;
      b_clr = 1'b1;
    end else if (key_pulse) begin
      case (state_q)
        ENTER_A: begin
          if (is_digit) begin
            a_push    = 1'b1;
            key_err_d = a_full;
          end else if (is_enter) begin
            b_clr     = !a_empty;
            key_err_d = a_empty;
          end else if (is_back) begin
            a_pop     = 1'b1;
            key_err_d = a_empty;
          end else if (is_bad) begin
            key_err_d = 1'b1;
          end
        end
        ENTER_B: begin
          if (is_digit) begin
            b_push    = 1'b1;
            key_err_d = b_full;
          end else if (is_enter) begin
            key_err_d = b_empty;
          end else if (is_back) begin
            // empty B: BACK steps back to A instead of erroring
            b_pop = 1'b1;
          end else if (is_bad) begin
            key_err_d = 1'b1;
          end
        end
        default: ;  // DONE ignores everything but CLEAR / handshake
      endcase
    end
  end

  assign sel_b     = (state_q != ENTER_A);
  assign ops_valid = (state_q == DONE);
  assign disp      = sel_b ? op_b : op_a;
  assign cnt       = sel_b ? b_cnt : a_cnt;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_module_control_entrada.sv
module tb_module_control_entrada;

  localparam int N  = 3;
  localparam int CW = $clog2(N + 1);
  localparam int W  = 4 * N;

  logic          clk = 1'b0;
  logic          rst_in, key_pulse, ops_ready;
  logic [3:0]    key_code;
  logic [W-1:0]  op_a, op_b, disp;
  logic [CW-1:0] cnt;
  logic          sel_b, ops_valid, key_err;

  typedef struct packed {
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  disp;
    logic [CW-1:0] cnt;
    logic          sel_b;
    logic          vld;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t act;
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model: mode 0=A, 1=B, 2=done; digits kept MS-first
  int         ms = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  always #5 clk = ~clk;

  module_control_entrada #(.N_DIGITS(N)) dut (
    .clk(clk), .rst_in(rst_in), .key_code(key_code), .key_pulse(key_pulse),
    .op_a(op_a), .op_b(op_b), .disp(disp), .cnt(cnt), .sel_b(sel_b),
    .ops_valid(ops_valid), .ops_ready(ops_ready), .key_err(key_err)
  );

  assign act = {op_a, op_b, disp, cnt, sel_b, ops_valid, key_err};

  function automatic logic [W-1:0] qv(input logic [3:0] q[$]);
    logic [W-1:0] v = '0;
    foreach (q[i]) v = v * 16 + W'(q[i]);
    return v;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got a=%h b=%h disp=%h cnt=%0d sel_b=%b vld=%b err=%b, want a=%h b=%h disp=%h cnt=%0d sel_b=%b vld=%b err=%b",
               name, $time, act.op_a, act.op_b, act.disp, act.cnt, act.sel_b, act.vld, act.err,
               e.op_a, e.op_b, e.disp, e.cnt, e.sel_b, e.vld, e.err);
    end
  endtask

  task automatic model_reset();
    ms = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input logic p, input logic [3:0] c, input logic r);
    logic err = 1'b0;
    exp_t e;
    if ((p && c == 4'hC) || (ms == 2 && r)) begin
      model_reset();
    end else if (p && ms != 2) begin
      if (c <= 4'd9) begin
        if (ms == 0) begin
          if (qa.size() == N) err = 1'b1; else qa.push_back(c);
        end else begin
          if (qb.size() == N) err = 1'b1; else qb.push_back(c);
        end
      end else if (c == 4'hA) begin
        if (ms == 0) begin
          if (qa.size() == 0) err = 1'b1;
          else begin ms = 1; qb.delete(); end
        end else begin
          if (qb.size() == 0) err = 1'b1; else ms = 2;
        end
      end else if (c == 4'hB) begin
        if (ms == 0) begin
          if (qa.size() == 0) err = 1'b1; else void'(qa.pop_back());
        end else begin
          if (qb.size() == 0) ms = 0; else void'(qb.pop_back());
        end
      end else begin
        err = 1'b1;
      end
    end
    e.op_a  = qv(qa);
    e.op_b  = qv(qb);
    e.disp  = (ms == 0) ? e.op_a : e.op_b;
    e.cnt   = (ms == 0) ? CW'(qa.size()) : CW'(qb.size());
    e.sel_b = (ms != 0);
    e.vld   = (ms == 2);
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // drive on the falling edge; expected result lands after the next rising edge
  task automatic step(input logic p, input logic [3:0] c, input logic r);
    @(negedge clk);
    key_pulse = p;
    key_code  = c;
    ops_ready = r;
    model_step(p, c, r);
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    key_pulse = 1'b0;
    ops_ready = 1'b0;
    #2 rst_in = 1'b0;
    #1 model_reset();
    check("async_rst", '0);
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  // monitor: every cycle the DUT presents a registered result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb", e);
      end
    end
  end

  initial begin
    rst_in    = 1'b0;
    key_pulse = 1'b0;
    key_code  = 4'h0;
    ops_ready = 1'b0;
    #3 check("reset", '0);
    @(negedge clk);
    rst_in = 1'b1;

    // fill A, overflow digit
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); idle();
    key(4'hC);
    // A=45, B=7, hold valid, then one-edge handshake
    key(4'h4); key(4'h5); key(4'hA); key(4'h7); key(4'hA);
    repeat (10) idle();
    step(1'b0, 4'h0, 1'b1); idle();
    // backspace within A and from empty B back to A
    key(4'h8); key(4'h9); key(4'hB); key(4'hA); key(4'hB); idle();
    key(4'hC);
    // errors in A, silent ignore in DONE, CLEAR + ready together
    key(4'hA); key(4'hE); key(4'hB);
    key(4'h1); key(4'hA); key(4'h2); key(4'hA);
    key(4'hE); key(4'h3); key(4'hB); key(4'hA);
    step(1'b1, 4'hC, 1'b1); idle();
    // ready outside DONE has no effect
    key(4'h6); step(1'b0, 4'h0, 1'b1); idle();
    // async reset mid-entry
    key(4'hC); key(4'h1); key(4'h2);
    async_reset();
    key(4'h3); idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int     r;
      logic [3:0] c;
      r = $urandom_range(0, 99);
      if (r < 60)      c = 4'($urandom_range(0, 9));
      else if (r < 75) c = 4'hA;
      else if (r < 87) c = 4'hB;
      else if (r < 92) c = 4'hC;
      else             c = 4'($urandom_range(13, 15));
      if ($urandom_range(0, 499) == 0) async_reset();
      step($urandom_range(0, 9) < 7, c, $urandom_range(0, 3) == 0);
    end

    idle();
    repeat (4) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/module_control_entrada.md
# module_control_entrada

Keypad entry controller sitting between `module_lectura` and the arithmetic/display datapath. It consumes one-cycle key strobes with a 4-bit key code and assembles two multi-digit decimal operands (BCD) through a small state machine with digit, enter, backspace and clear keys. It presents the finished operand pair to the downstream consumer with a valid/ready handshake, and drives the operand currently being edited to the display path.

## Interface
- `N_DIGITS`, default 3: maximum BCD digits per operand (≥1).
- `CW`, default `$clog2(N_DIGITS+1)`: digit-count width (derived; not overridden).

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_in`  in  1: reset, asynchronous, active-low.
- `key_code`  in  4: key value from `module_lectura`; sampled only when `key_pulse`=1.
- `key_pulse`  in  1: one-cycle strobe per debounced key press.
- `op_a`  out  4·N_DIGITS: operand A, BCD, least-significant digit in bits [3:0].
- `op_b`  out  4·N_DIGITS: operand B, same format.
- `disp`  out  4·N_DIGITS: the operand being edited (A in ENTER_A; B in ENTER_B and DONE).
- `cnt`  out  CW: number of digits in the operand being edited.
- `sel_b`  out  1: 1 when operand B is selected (ENTER_B or DONE).
- `ops_valid`  out  1: operand pair complete; held until accepted.
- `ops_ready`  in  1: consumer accepts the pair.
- `key_err`  out  1: one-cycle pulse when a key is rejected.

## Operation
- Reset values: state ENTER_A; `op_a`=`op_b`=0; both counts 0; `disp`=0; `cnt`=0; `sel_b`=0; `ops_valid`=0; `key_err`=0.
- Key classes:
  - 0x0–0x9: digit.
  - 0xA: ENTER.
  - 0xB: BACK.
  - 0xC: CLEAR.
  - 0xD–0xF: invalid. These pulse `key_err` in ENTER_A and ENTER_B only.
- **Digit, ENTER_x:**
  - If count < N_DIGITS: operand ← (operand << 4) | digit, truncated to 4·N_DIGITS bits; count+1.
  - If count = N_DIGITS: no change; `key_err`.
- **ENTER:**
  - ENTER_A with count_a ≥ 1: go to ENTER_B with op_b=0 and count_b=0.
  - ENTER_B with count_b ≥ 1: go to DONE; `ops_valid`=1.
  - Count 0: no change; `key_err`.
- **BACK:**
  - Count > 0: operand ← operand >> 4; count−1.
  - ENTER_B with count_b=0: return to ENTER_A. op_a and count_a are kept.
  - ENTER_A with count_a=0: `key_err`.
- **CLEAR:** valid in any state. Go to ENTER_A with all operands and counts zeroed and `ops_valid`=0. CLEAR has priority over every other event.
- **DONE:**
  - Digit, ENTER, BACK and invalid keys are ignored silently (no `key_err`).
  - `ops_valid`=1 and `ops_ready`=1 at a rising edge complete the transfer. The block then goes to ENTER_A, and operands and counts clear on the same edge.
- `ops_ready` outside DONE has no effect.

## Timing
- `key_pulse` is sampled at the rising edge. All outputs are registered and reflect the key one cycle later (latency 1).
- Consecutive-cycle strobes are each processed in order; there is no required gap.
- `key_err` is high for exactly the cycle following the rejected strobe.
- `ops_valid` rises in the cycle after the accepting ENTER. It falls in the cycle after the handshake edge, or after CLEAR.
- CLEAR and `ops_ready` on the same DONE edge: the result is ENTER_A with everything zeroed, the same as either event alone. The consumer treats the transfer as completed.
- `rst_in` low at any time, including mid-entry or in DONE: all outputs go to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `pkg_teclado`:
  - Constants `KEY_ENTER`=4'hA, `KEY_BACK`=4'hB, `KEY_CLR`=4'hC.
  - State enum `entrada_t` {ENTER_A, ENTER_B, DONE}.
- One sub-module `module_operando`, instantiated twice (A and B). It holds the BCD shift register and digit count, and implements push, pop and clear operations with full/empty flags.
- The top level holds only the FSM, key decode and output muxing.

## Test plan
- Reset, then keys 1,2,3 → `disp`=0x123, `cnt`=3. A 4th key 4 → `disp` unchanged and `key_err` pulses for 1 cycle.
- Keys 4,5,ENTER,7,ENTER → `op_a`=0x045, `op_b`=0x007, `ops_valid`=1 held while `ops_ready`=0 for 10 cycles. `ops_ready`=1 for one edge → `ops_valid`=0, state ENTER_A, operands 0.
- Keys 8,9,BACK → `disp`=0x008, `cnt`=1. Then ENTER, BACK (count_b=0) → `sel_b`=0, `disp`=0x008, `cnt`=1.
- ENTER with count 0, and key 0xE in ENTER_A → `key_err` for each, no state change. Key 0xE in DONE → no `key_err`.
- In DONE, assert CLEAR strobe and `ops_ready` on the same edge → ENTER_A, all zero, `ops_valid`=0.
- Drop `rst_in` low asynchronously mid-entry (`disp`=0x012) → outputs zero before the next clock edge. After release, key 3 → `disp`=0x003.
